pn_ber_checker: RTL



---
 rtl/pn_ber_checker.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pn_ber_checker.sv
// Purpose: self-synchronising PRBS checker with saturating bit/error/loss counters and loss-of-lock detection.
// Latency: locked/state/err_pulse/counters update in the cycle after the deciding valid bit is sampled.
// Backpressure: none; data_valid=0 stalls all sync/count state (only clear and rst act).
// Optional feature macro: PN_BER_CHECKER_AUTO_INVERT_EN (lock to an inverted PRBS, adds output 'inverted').
module pn_ber_checker #(
    parameter int          PN_WIDTH    = 7,
    parameter int unsigned PN_TAPS     = 'h60,
    parameter int          LOCK_COUNT  = 16,
    parameter int          WINDOW      = 64,
    parameter int          LOSS_THRESH = 8,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 data_valid,
    input  logic                 clear,
    output logic                 locked,
    output logic [1:0]           state,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [7:0]           loss_count
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
    ,
    output logic                 inverted
`endif
);

    localparam int FILL_W = $clog2(PN_WIDTH + 1);
    localparam int WIN_W  = $clog2(WINDOW);
    localparam int WERR_W = $clog2(WINDOW + 1);
    localparam logic [PN_WIDTH-1:0] TAP_MASK = PN_WIDTH'(PN_TAPS);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t                 state_q;
    logic [PN_WIDTH-1:0]    shift_q;
    logic [FILL_W-1:0]      fill_q;
    logic [7:0]             match_q;
    logic [WIN_W-1:0]       win_cnt_q;
    logic [WERR_W-1:0]      win_err_q;
    logic [CNT_WIDTH-1:0]   bit_cnt_q;
    logic [CNT_WIDTH-1:0]   err_cnt_q;
    logic [7:0]             loss_cnt_q;
    logic                   locked_q;
    logic                   err_pulse_q;
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
    logic [7:0]             inv_match_q;
    logic                   inv_mode_q;
    logic                   inverted_q;
    logic                   verify_first;
    logic                   verify_sel_inv;
`endif

    logic                   pred;
    logic                   verify_pol;
    logic                   lock_pol;
    logic                   verify_mis;
    logic                   verify_ok;
    logic                   lock_mis;
    logic                   shift_bit;
    logic [PN_WIDTH-1:0]    shift_d;
    logic [7:0]             verify_cnt_d;
    logic [WERR_W-1:0]      win_err_d;
    logic                   win_last;
    logic [CNT_WIDTH-1:0]   bit_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_d;
    logic [7:0]             loss_cnt_d;

    // Prediction, compare results and next-value helpers for the FSM
    always_comb begin
        pred = ^(shift_q & TAP_MASK);
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
        // Before any VERIFY bit, neither polarity has been chosen; the first bit picks it.
        verify_first   = (match_q == 8'd0) && (inv_match_q == 8'd0);
        verify_pol     = (inv_match_q != 8'd0);
        lock_pol       = inv_mode_q;
        verify_mis     = (data_in != (pred ^ verify_pol));
        verify_ok      = verify_first || !verify_mis;
        verify_sel_inv = verify_first ? verify_mis : verify_pol;
        verify_cnt_d   = (verify_sel_inv ? inv_match_q : match_q) + 8'd1;
`else
        verify_pol     = 1'b0;
        lock_pol       = 1'b0;
        verify_mis     = (data_in != pred);
        verify_ok      = !verify_mis;
        verify_cnt_d   = match_q + 8'd1;
`endif
        lock_mis = (data_in != (pred ^ lock_pol));

        // Register stays in the received-bit domain: HUNT and the polarity-choosing
        // bit take data_in, afterwards the expected bit free-runs so errors do not propagate.
        case (state_q)
            HUNT:    shift_bit = data_in;
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
            VERIFY:  shift_bit = verify_first ? data_in : (pred ^ verify_pol);
`else
            VERIFY:  shift_bit = pred ^ verify_pol;
`endif
            default: shift_bit = pred ^ lock_pol;
        endcase
        shift_d = {shift_q[PN_WIDTH-2:0], shift_bit};

        win_last   = (win_cnt_q == WIN_W'(WINDOW - 1));
        win_err_d  = win_err_q + WERR_W'(lock_mis);
        bit_cnt_d  = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + CNT_WIDTH'(1);
        err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_WIDTH'(1);
        loss_cnt_d = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
    end

    // Sync FSM, window evaluation and counters; clear overrides any same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            shift_q     <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            loss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
            inv_match_q <= '0;
            inv_mode_q  <= 1'b0;
            inverted_q  <= 1'b0;
`endif
        end else begin
            err_pulse_q <= 1'b0;
            if (data_valid) begin
                shift_q <= shift_d;
                case (state_q)
                    HUNT: begin
                        if (fill_q == FILL_W'(PN_WIDTH - 1)) begin
                            fill_q <= '0;
                            // All-zero is the LFSR lock-up state: refill instead of verifying.
                            if (shift_d != '0) begin
                                state_q <= VERIFY;
                                match_q <= '0;
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
                                inv_match_q <= '0;
`endif
                            end
                        end else begin
                            fill_q <= fill_q + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (!verify_ok) begin
                            state_q <= HUNT;
                            fill_q  <= '0;
                        end else if (verify_cnt_d == 8'(LOCK_COUNT)) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            win_cnt_q <= '0;
                            win_err_q <= '0;
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
                            inv_mode_q <= verify_sel_inv;
                            inverted_q <= verify_sel_inv;
`endif
                        end else begin
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
                            if (verify_sel_inv)
                                inv_match_q <= verify_cnt_d;
                            else
`endif
                                match_q <= verify_cnt_d;
                        end
                    end
                    LOCKED: begin
                        bit_cnt_q   <= bit_cnt_d;
                        err_pulse_q <= lock_mis;
                        if (lock_mis)
                            err_cnt_q <= err_cnt_d;
                        if (win_last) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                            // The window's last bit is included in the threshold test.
                            if (win_err_d >= WERR_W'(LOSS_THRESH)) begin
                                state_q    <= HUNT;
                                locked_q   <= 1'b0;
                                fill_q     <= '0;
                                loss_cnt_q <= loss_cnt_d;
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
                                inv_mode_q <= 1'b0;
                                inverted_q <= 1'b0;
`endif
                            end
                        end else begin
                            win_cnt_q <= win_cnt_q + WIN_W'(1);
                            win_err_q <= win_err_d;
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                        fill_q   <= '0;
                    end
                endcase
            end
            if (clear) begin
                bit_cnt_q  <= '0;
                err_cnt_q  <= '0;
                loss_cnt_q <= '0;
            end
        end
    end

    assign locked     = locked_q;
    assign state      = state_q;
    assign err_pulse  = err_pulse_q;
    assign bit_count  = bit_cnt_q;
    assign err_count  = err_cnt_q;
    assign loss_count = loss_cnt_q;
`ifdef PN_BER_CHECKER_AUTO_INVERT_EN
    assign inverted   = inverted_q;
`endif

endmodule
